// File: rtl/digest_matcher_if.sv
// Handshake bundle between the cracker datapath and digest_matcher.
// master = cracker side (drives target bytes and digests), slave = matcher.
interface digest_matcher_if #(
    parameter int DIGEST_W = 256,
    parameter int ID_W     = 32
);
    logic [7:0]          tgt_byte;
    logic                tgt_valid;
    logic                tgt_ready;
    logic                tgt_reload;
    logic                tgt_loaded;
    logic [DIGEST_W-1:0] digest_in;
    logic                digest_done;
    logic [ID_W-1:0]     cand_id;
    logic                busy;
    logic                result_valid;
    logic                result_hit;
    logic                found;
    logic [ID_W-1:0]     found_id;
    logic                overrun;

    modport master (
        output tgt_byte, tgt_valid, tgt_reload, digest_in, digest_done, cand_id,
        input  tgt_ready, tgt_loaded, busy, result_valid, result_hit, found,
               found_id, overrun
    );

    modport slave (
        input  tgt_byte, tgt_valid, tgt_reload, digest_in, digest_done, cand_id,
        output tgt_ready, tgt_loaded, busy, result_valid, result_hit, found,
               found_id, overrun
    );
endinterface

// File: rtl/digest_matcher.sv
// Holds a byte-loaded target hash and compares each finished digest against it
// one word per cycle (H0 first, early exit on mismatch); latches the first hit ID.
//
// state     | meaning
// S_LOAD    | shifting in target bytes, tgt_ready=1
// S_IDLE    | target held, waiting for a digest_done rising edge or reload
// S_COMPARE | comparing captured digest word by word, busy=1
// S_REPORT  | result_valid pulse visible, returning to IDLE
module digest_matcher #(
    parameter int DIGEST_W = 256,
    parameter int WORD_W   = 32,
    parameter int ID_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    digest_matcher_if.slave bus
);
    localparam int NWORDS = DIGEST_W / WORD_W;
    localparam int NBYTES = DIGEST_W / 8;
    localparam int K_W    = $clog2(NWORDS);
    localparam int C_W    = $clog2(NBYTES);

    typedef enum logic [1:0] {S_LOAD, S_IDLE, S_COMPARE, S_REPORT} state_t;

    state_t              state;
    logic [C_W-1:0]      byte_cnt;
    logic [K_W-1:0]      word_idx;
    logic [DIGEST_W-1:0] tgt_flat;
    logic [DIGEST_W-1:0] digest_q;
    logic [ID_W-1:0]     id_q;
    logic                done_q;
    logic                new_edge;

    logic                tgt_ready_q;
    logic                tgt_loaded_q;
    logic                busy_q;
    logic                result_valid_q;
    logic                result_hit_q;
    logic                found_q;
    logic [ID_W-1:0]     found_id_q;
    logic                overrun_q;

    // Word views: index NWORDS-1 is the most significant word (H0), so the
    // compare walks word_idx downward and finishes at 0.
    logic [NWORDS-1:0][WORD_W-1:0] tgt_words;
    logic [NWORDS-1:0][WORD_W-1:0] dig_words;

    assign tgt_words = tgt_flat;
    assign dig_words = digest_q;
    assign new_edge  = bus.digest_done & ~done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_LOAD;
            byte_cnt       <= '0;
            word_idx       <= '0;
            tgt_flat       <= '0;
            digest_q       <= '0;
            id_q           <= '0;
            done_q         <= 1'b0;
            tgt_ready_q    <= 1'b1;
            tgt_loaded_q   <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_hit_q   <= 1'b0;
            found_q        <= 1'b0;
            found_id_q     <= '0;
            overrun_q      <= 1'b0;
        end else begin
            done_q         <= bus.digest_done;
            result_valid_q <= 1'b0;
            result_hit_q   <= 1'b0;
            unique case (state)
                S_LOAD: begin
                    if (new_edge) overrun_q <= 1'b1;
                    if (bus.tgt_valid) begin
                        tgt_flat <= {tgt_flat[DIGEST_W-9:0], bus.tgt_byte};
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == C_W'(NBYTES - 1)) begin
                            state        <= S_IDLE;
                            tgt_loaded_q <= 1'b1;
                            tgt_ready_q  <= 1'b0;
                        end
                    end
                end
                S_IDLE: begin
                    // Reload has priority; a coincident edge is lost and flagged.
                    if (bus.tgt_reload) begin
                        state        <= S_LOAD;
                        tgt_flat     <= '0;
                        byte_cnt     <= '0;
                        tgt_loaded_q <= 1'b0;
                        tgt_ready_q  <= 1'b1;
                        found_q      <= 1'b0;
                        found_id_q   <= '0;
                        if (new_edge) overrun_q <= 1'b1;
                    end else if (new_edge) begin
                        state    <= S_COMPARE;
                        digest_q <= bus.digest_in;
                        id_q     <= bus.cand_id;
                        word_idx <= K_W'(NWORDS - 1);
                        busy_q   <= 1'b1;
                    end
                end
                S_COMPARE: begin
                    if (new_edge) overrun_q <= 1'b1;
                    if (dig_words[word_idx] != tgt_words[word_idx]) begin
                        state          <= S_REPORT;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                        result_hit_q   <= 1'b0;
                    end else if (word_idx == '0) begin
                        state          <= S_REPORT;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                        result_hit_q   <= 1'b1;
                        if (!found_q) begin
                            found_q    <= 1'b1;
                            found_id_q <= id_q;
                        end
                    end else begin
                        word_idx <= word_idx - 1'b1;
                    end
                end
                S_REPORT: begin
                    if (new_edge) overrun_q <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign bus.tgt_ready    = tgt_ready_q;
    assign bus.tgt_loaded   = tgt_loaded_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_hit   = result_hit_q;
    assign bus.found        = found_q;
    assign bus.found_id     = found_id_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_digest_matcher.sv
// Randomised + directed bench for digest_matcher against a cycle-timed
// behavioural model built from the timing rules (capture cycle, result latency).
module tb_digest_matcher;
    localparam int DIGEST_W = 256;
    localparam int WORD_W   = 32;
    localparam int ID_W     = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    digest_matcher_if #(.DIGEST_W(DIGEST_W), .ID_W(ID_W)) bus ();

    digest_matcher #(.DIGEST_W(DIGEST_W), .WORD_W(WORD_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_rv    = 0;

    logic [31:0] abc_w [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    logic [31:0] dig_w [8];

    // reference model state
    int          cyc = 0;
    bit          m_loaded;
    int          m_nbytes;
    logic [7:0]  m_bytes [32];
    bit          m_prev;
    bit          m_pend;
    int          m_cap;
    int          m_res;
    bit          m_hit;
    logic [31:0] m_id_pend;
    bit          m_found;
    logic [31:0] m_found_id;
    bit          m_ovr;
    bit          e_rv;
    bit          e_hit;
    bit          e_busy;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] tgt_word(input int j);
        return {m_bytes[4*j], m_bytes[4*j+1], m_bytes[4*j+2], m_bytes[4*j+3]};
    endfunction

    task automatic model_update();
        bit edge_now;
        int k;
        edge_now = bus.digest_done && !m_prev;
        m_prev   = bus.digest_done;
        cyc++;
        e_rv  = 1'b0;
        e_hit = 1'b0;
        if (rst) begin
            m_loaded = 0; m_nbytes = 0; m_pend = 0; m_found = 0;
            m_found_id = '0; m_ovr = 0; m_prev = 0;
        end else begin
            if (!m_loaded) begin
                if (edge_now) m_ovr = 1;
                if (bus.tgt_valid) begin
                    m_bytes[m_nbytes] = bus.tgt_byte;
                    m_nbytes++;
                    if (m_nbytes == 32) m_loaded = 1;
                end
            end else if (m_pend && cyc <= m_res + 1) begin
                if (edge_now) m_ovr = 1;
            end else if (bus.tgt_reload) begin
                m_loaded = 0; m_nbytes = 0; m_pend = 0; m_found = 0; m_found_id = '0;
                for (int i = 0; i < 32; i++) m_bytes[i] = '0;
                if (edge_now) m_ovr = 1;
            end else if (edge_now) begin
                k = 8;
                for (int j = 7; j >= 0; j--) if (dig_w[j] != tgt_word(j)) k = j;
                m_pend    = 1;
                m_cap     = cyc;
                m_hit     = (k == 8);
                m_res     = cyc + (m_hit ? 8 : k + 1);
                m_id_pend = bus.cand_id;
            end
            if (m_pend && cyc == m_res) begin
                e_rv  = 1'b1;
                e_hit = m_hit;
                if (m_hit && !m_found) begin
                    m_found    = 1;
                    m_found_id = m_id_pend;
                end
            end
        end
        e_busy = m_pend && cyc >= m_cap && cyc < m_res;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        if (bus.result_valid === 1'b1) n_rv++;
        check_eq("result_valid", bus.result_valid, e_rv);
        check_eq("result_hit",   bus.result_hit,   e_hit);
        check_eq("busy",         bus.busy,         e_busy);
        check_eq("found",        bus.found,        m_found);
        check_eq("found_id",     bus.found_id,     m_found_id);
        check_eq("overrun",      bus.overrun,      m_ovr);
        check_eq("tgt_ready",    bus.tgt_ready,    !m_loaded);
        check_eq("tgt_loaded",   bus.tgt_loaded,   m_loaded);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive_digest();
        bus.digest_in = {dig_w[0], dig_w[1], dig_w[2], dig_w[3],
                         dig_w[4], dig_w[5], dig_w[6], dig_w[7]};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic load_words(input logic [31:0] w [8]);
        logic [31:0] tmp;
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.tgt_valid = 1'b0;
                step();
            end
            tmp = w[i/4] >> (24 - 8 * (i % 4));
            bus.tgt_byte  = tmp[7:0];
            bus.tgt_valid = 1'b1;
            step();
        end
        bus.tgt_valid = 1'b0;
    endtask

    // Raise digest_done for 'hold' cycles with the current dig_w and given ID.
    task automatic fire(input logic [31:0] id, input int hold);
        drive_digest();
        bus.cand_id     = id;
        bus.digest_done = 1'b1;
        idle(hold);
        bus.digest_done = 1'b0;
    endtask

    int rv_base;

    initial begin
        rst             = 1'b1;
        bus.tgt_byte    = '0;
        bus.tgt_valid   = 1'b0;
        bus.tgt_reload  = 1'b0;
        bus.digest_in   = '0;
        bus.digest_done = 1'b0;
        bus.cand_id     = '0;
        for (int i = 0; i < 32; i++) m_bytes[i] = '0;
        for (int j = 0; j < 8; j++) dig_w[j] = '0;

        do_reset();
        check_eq("reset_ready", bus.tgt_ready, 1);
        check_eq("reset_found", bus.found, 0);

        load_words(abc_w);
        idle(2);
        check_eq("abc_loaded", bus.tgt_loaded, 1);

        // exact hit, ID 5
        for (int j = 0; j < 8; j++) dig_w[j] = abc_w[j];
        rv_base = n_rv;
        fire(32'd5, 1);
        idle(12);
        check_eq("abc_one_result", n_rv - rv_base, 1);
        check_eq("abc_found_id", bus.found_id, 32'd5);

        // miss in H0, then miss in H7 low bit
        dig_w[0] = abc_w[0] ^ 32'h8000_0000;
        fire(32'd6, 1);
        idle(6);
        dig_w[0] = abc_w[0];
        dig_w[7] = abc_w[7] ^ 32'h1;
        fire(32'd7, 1);
        idle(12);
        dig_w[7] = abc_w[7];

        // held-high done yields a single result
        rv_base = n_rv;
        fire(32'd8, 10);
        idle(4);
        check_eq("held_one_pulse", n_rv - rv_base, 1);
        check_eq("held_no_overrun", bus.overrun, 0);

        // second edge 3 cycles after the first is dropped
        rv_base = n_rv;
        fire(32'd9, 1);
        idle(2);
        fire(32'd10, 1);
        idle(12);
        check_eq("overlap_one_result", n_rv - rv_base, 1);
        check_eq("overlap_overrun", bus.overrun, 1);
        check_eq("second_hit_keeps_id", bus.found_id, 32'd5);

        // reload coincident with edge in IDLE
        bus.tgt_reload = 1'b1;
        fire(32'd11, 1);
        bus.tgt_reload = 1'b0;
        idle(2);
        check_eq("reload_found_clear", bus.found, 0);
        check_eq("reload_ready", bus.tgt_ready, 1);

        // edge while unloaded
        rv_base = n_rv;
        fire(32'd12, 1);
        idle(3);
        check_eq("unloaded_no_result", n_rv - rv_base, 0);
        load_words(abc_w);
        idle(2);

        // reset in the middle of a compare
        do_reset();
        load_words(abc_w);
        idle(1);
        rv_base = n_rv;
        fire(32'd13, 1);
        idle(3);
        do_reset();
        idle(10);
        check_eq("midrst_no_result", n_rv - rv_base, 0);
        check_eq("midrst_ready", bus.tgt_ready, 1);
        check_eq("midrst_overrun", bus.overrun, 0);

        // randomised phase
        for (int c = 0; c < 4000; c++) begin
            bus.tgt_valid  = ($urandom_range(0, 1) == 1);
            bus.tgt_byte   = 8'($urandom);
            bus.tgt_reload = ($urandom_range(0, 79) == 0);
            rst            = ($urandom_range(0, 999) == 0);
            if (!bus.digest_done && $urandom_range(0, 5) == 0) begin
                for (int j = 0; j < 8; j++) dig_w[j] = tgt_word(j);
                if ($urandom_range(0, 1) == 1)
                    dig_w[$urandom_range(0, 7)] ^= (32'h1 << $urandom_range(0, 31));
                drive_digest();
                bus.cand_id     = $urandom;
                bus.digest_done = 1'b1;
            end else if (bus.digest_done && $urandom_range(0, 2) == 0) begin
                bus.digest_done = 1'b0;
            end
            step();
        end
        rst = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
